// File: rtl/neuro_pkg.sv
// Shared types and the width-parametrised saturating adder for the neuron datapath.
package neuro_pkg;

    typedef enum logic [1:0] {
        FA_BIPOLAR  = 2'b00,
        FA_RAMPA    = 2'b01,
        FA_RELU     = 2'b10,
        FA_UNIPOLAR = 2'b11
    } fa_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACT,
        ST_DONE
    } state_t;

    localparam int SAT_MAX_W = 64;

    // Adds two sign-extended operands and clamps the sum to the signed range of w bits (w <= 64).
    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int                          w
    );
        logic signed [SAT_MAX_W:0] s;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        s  = (SAT_MAX_W+1)'(a) + (SAT_MAX_W+1)'(b);
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (s > hi)
            return SAT_MAX_W'(hi);
        else if (s < lo)
            return SAT_MAX_W'(lo);
        else
            return SAT_MAX_W'(s);
    endfunction

endpackage

// File: rtl/neuronio_stream_funcao_ativacao.sv
// Combinational activation: rescales the accumulator by SHIFT, clamps to +/-(2^(OW-1)-1)
// and applies the selected transfer function.
module funcao_ativacao_param
    import neuro_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int OW    = 8,
    parameter int SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    input  fa_t                     fa,
    output logic signed [OW-1:0]    y
);

    localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((1 << (OW - 1)) - 1);
    localparam logic signed [OW-1:0]    OMAX = OW'((1 << (OW - 1)) - 1);

    logic signed [ACC_W-1:0] r;
    logic signed [ACC_W-1:0] rs;

    always_comb begin
        r = acc >>> SHIFT;
        if (r > PMAX)
            rs = PMAX;
        else if (r < -PMAX)
            rs = -PMAX;
        else
            rs = r;

        y = '0;
        case (fa)
            FA_BIPOLAR:  y = acc[ACC_W-1] ? -OMAX : OMAX;
            FA_RAMPA:    y = OW'(rs);
            FA_RELU:     y = rs[ACC_W-1] ? '0 : OW'(rs);
            FA_UNIPOLAR: y = acc[ACC_W-1] ? '0 : OMAX;
            default:     y = '0;
        endcase
    end

endmodule

// File: rtl/neuronio_stream.sv
// Streaming neuron: accumulates (ix, iw) beats with saturation, applies an activation in one
// registered cycle, then holds the result until the consumer takes it.
module neuronio_stream
    import neuro_pkg::*;
#(
    parameter int MAX_IN = 32,
    parameter int XW     = 8,
    parameter int WW     = 16,
    parameter int ACC_W  = 32,
    parameter int OW     = 8,
    parameter int SHIFT  = 8,
    parameter int CW     = $clog2(MAX_IN + 1)
) (
    input  logic                 clk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [CW-1:0]        iQtdEntradas,
    input  logic [1:0]           iCtrlFA,
    input  logic                 iFlagBias,
    input  logic signed [WW-1:0] iBias,
    input  logic                 iEnable,
    input  logic signed [XW-1:0] ix,
    input  logic signed [WW-1:0] iw,
    input  logic                 iValid,
    output logic                 oReady,
    output logic signed [OW-1:0] oN,
    output logic                 oFlagNeuro,
    input  logic                 iReady
);

    localparam int PW = XW + WW;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           qtd_q, qtd_d;
    fa_t                     fa_q, fa_d;
    logic                    en_q, en_d;
    logic signed [OW-1:0]    on_q, on_d;

    logic [CW-1:0]           qtd_clamp;
    logic signed [PW-1:0]    prod;
    logic signed [OW-1:0]    act_y;

    funcao_ativacao_param #(
        .ACC_W (ACC_W),
        .OW    (OW),
        .SHIFT (SHIFT)
    ) u_fa (
        .acc (acc_q),
        .fa  (fa_q),
        .y   (act_y)
    );

    assign oReady     = (state_q == ST_LOAD);
    assign oFlagNeuro = (state_q == ST_DONE);
    assign oN         = on_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        qtd_d   = qtd_q;
        fa_d    = fa_q;
        en_d    = en_q;
        on_d    = on_q;

        qtd_clamp = (iQtdEntradas > CW'(MAX_IN)) ? CW'(MAX_IN) : iQtdEntradas;
        prod      = PW'(ix) * PW'(iw);

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    qtd_d   = qtd_clamp;
                    fa_d    = fa_t'(iCtrlFA);
                    en_d    = iEnable;
                    acc_d   = iFlagBias ? ACC_W'(iBias) : '0;
                    cnt_d   = '0;
                    state_d = (qtd_clamp == '0) ? ST_ACT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (iValid) begin
                    acc_d = ACC_W'(sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(prod), ACC_W));
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == qtd_q)
                        state_d = ST_ACT;
                end
            end
            ST_ACT: begin
                // A disabled neuron still drains its beats so sibling neurons stay aligned.
                on_d    = en_q ? act_y : '0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (iReady)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            qtd_q   <= '0;
            fa_q    <= FA_BIPOLAR;
            en_q    <= 1'b0;
            on_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            qtd_q   <= qtd_d;
            fa_q    <= fa_d;
            en_q    <= en_d;
            on_q    <= on_d;
        end
    end

endmodule

// File: tb/tb_neuronio_stream.sv
// Randomized scoreboard bench for neuronio_stream with a 24-bit accumulator so saturation is reachable.
module tb_neuronio_stream;

    localparam int MAX_IN = 32;
    localparam int ACC_W  = 24;
    localparam int CW     = 6;

    logic                clk = 1'b0;
    logic                iRst = 1'b1;
    logic                iStart = 1'b0;
    logic [CW-1:0]       iQtdEntradas = '0;
    logic [1:0]          iCtrlFA = '0;
    logic                iFlagBias = 1'b0;
    logic signed [15:0]  iBias = '0;
    logic                iEnable = 1'b0;
    logic signed [7:0]   ix = '0;
    logic signed [15:0]  iw = '0;
    logic                iValid = 1'b0;
    logic                oReady;
    logic signed [7:0]   oN;
    logic                oFlagNeuro;
    logic                iReady = 1'b0;

    neuronio_stream #(
        .MAX_IN (MAX_IN), .XW (8), .WW (16), .ACC_W (ACC_W), .OW (8), .SHIFT (8), .CW (CW)
    ) dut (
        .clk          (clk),
        .iRst         (iRst),
        .iStart       (iStart),
        .iQtdEntradas (iQtdEntradas),
        .iCtrlFA      (iCtrlFA),
        .iFlagBias    (iFlagBias),
        .iBias        (iBias),
        .iEnable      (iEnable),
        .ix           (ix),
        .iw           (iw),
        .iValid       (iValid),
        .oReady       (oReady),
        .oN           (oN),
        .oFlagNeuro   (oFlagNeuro),
        .iReady       (iReady)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int xs[40];
    int ws[40];
    int exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer dot product with clamp after every beat, floor scaling, then the transfer rule.
    function automatic int model(input int n, input int fa, input bit bflag, input int bias, input bit en);
        longint amax = (longint'(1) << (ACC_W - 1)) - 1;
        longint amin = -(longint'(1) << (ACC_W - 1));
        longint acc  = bflag ? longint'(bias) : 0;
        longint r;
        longint rs;
        for (int i = 0; i < n; i++) begin
            acc = acc + longint'(xs[i]) * longint'(ws[i]);
            if (acc > amax) acc = amax;
            if (acc < amin) acc = amin;
        end
        r  = (acc >= 0) ? acc / 256 : -((-acc + 255) / 256);
        rs = (r > 127) ? 127 : ((r < -127) ? -127 : r);
        if (!en) return 0;
        case (fa)
            0:       return (acc >= 0) ? 127 : -127;
            1:       return int'(rs);
            2:       return (rs < 0) ? 0 : int'(rs);
            default: return (acc >= 0) ? 127 : 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!iRst && oFlagNeuro) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                check("oN", oN, exp_q[0]);
                if (iReady) void'(exp_q.pop_front());
            end
        end
    end

    // One evaluation. rst_after>0 resets after that many beats; hold<0 picks a random iReady stall.
    task automatic run(input int qtd, input int fa, input bit bflag, input int bias, input bit en,
                       input bit gaps, input int hold, input int rst_after, input bit start_mid,
                       input bit start_in_done);
        int qc = (qtd > MAX_IN) ? MAX_IN : qtd;
        int waitc;
        int h = (hold < 0) ? int'($urandom_range(0, 5)) : hold;
        if (rst_after <= 0) exp_q.push_back(model(qc, fa, bflag, bias, en));
        @(posedge clk); #1;
        iStart = 1'b1; iQtdEntradas = CW'(qtd); iCtrlFA = 2'(fa);
        iFlagBias = bflag; iBias = 16'(bias); iEnable = en;
        @(posedge clk); #1;
        iStart = 1'b0;
        iCtrlFA = 2'($urandom); iEnable = 1'($urandom); iBias = 16'($urandom); iFlagBias = 1'($urandom);
        for (int i = 0; i < qc; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                iValid = 1'b0; ix = 8'($urandom); iw = 16'($urandom);
                @(posedge clk); #1;
            end
            iValid = 1'b1; ix = 8'(xs[i]); iw = 16'(ws[i]);
            if (start_mid && i == 1) begin
                iStart = 1'b1; iQtdEntradas = CW'(1);
            end
            waitc = 0;
            @(negedge clk);
            while (!oReady && waitc < 50) begin
                waitc++;
                @(negedge clk);
            end
            if (!oReady) begin
                check("beat_timeout", 0, 1);
                $display("FAIL run_abort oReady never rose");
                $fatal(1);
            end
            @(posedge clk); #1;
            iStart = 1'b0;
            if (i + 1 == rst_after) begin
                iValid = 1'b0; iRst = 1'b1;
                @(posedge clk); #1;
                iRst = 1'b0;
                @(negedge clk);
                check("rst_oN", oN, 0);
                check("rst_flag", oFlagNeuro, 0);
                check("rst_ready", oReady, 0);
                return;
            end
        end
        ix = 8'($urandom); iw = 16'($urandom);
        @(negedge clk);
        check("no_extra_beat", oReady, 0);
        check("lat_act_flag", oFlagNeuro, 0);
        @(posedge clk); #1;
        iValid = 1'b0;
        @(negedge clk);
        check("lat_done_flag", oFlagNeuro, 1);
        repeat (h) begin
            @(negedge clk);
            check("hold_flag", oFlagNeuro, 1);
        end
        @(posedge clk); #1;
        iReady = 1'b1; iStart = start_in_done;
        @(posedge clk); #1;
        iReady = 1'b0; iStart = 1'b0;
        @(negedge clk);
        check("flag_drop", oFlagNeuro, 0);
        check("idle_not_loading", oReady, 0);
    endtask

    task automatic load_basic();
        xs[0] = 10;  ws[0] = 256;
        xs[1] = 20;  ws[1] = 128;
        xs[2] = -5;  ws[2] = 512;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 iRst = 1'b0;
        @(negedge clk);
        check("reset_oN", oN, 0);
        check("reset_flag", oFlagNeuro, 0);
        check("reset_ready", oReady, 0);

        load_basic();
        run(3, 1, 1, 100, 1, 0, 0, 0, 0, 0);

        xs[0] = -100; ws[0] = 1000;
        for (int f = 0; f < 4; f++) run(1, f, 0, 0, 1, 0, -1, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin xs[i] = 127; ws[i] = 32767; end
        run(4, 0, 0, 0, 1, 0, -1, 0, 0, 0);
        run(4, 1, 0, 0, 1, 0, -1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin xs[i] = -128; ws[i] = 32767; end
        run(4, 1, 1, -32768, 1, 0, -1, 0, 0, 0);

        xs[0] = 50; ws[0] = 900; xs[1] = 60; ws[1] = 700;
        run(2, 1, 0, 0, 0, 1, 5, 0, 0, 0);

        run(0, 1, 1, -300, 1, 0, 2, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin xs[i] = int'($urandom_range(0, 255)) - 128; ws[i] = int'($urandom_range(0, 65535)) - 32768; end
        run(40, 1, 0, 0, 1, 1, -1, 0, 0, 1);

        load_basic();
        run(3, 1, 1, 100, 1, 0, 0, 2, 0, 0);
        run(3, 1, 1, 100, 1, 1, -1, 0, 1, 0);

        for (int t = 0; t < 30; t++) begin
            int n = int'($urandom_range(0, 34));
            bit big = 1'($urandom);
            for (int i = 0; i < 40; i++) begin
                xs[i] = big ? (1'($urandom) ? 127 : -128) : int'($urandom_range(0, 255)) - 128;
                ws[i] = big ? (1'($urandom) ? 32767 : -32768) : int'($urandom_range(0, 65535)) - 32768;
            end
            run(n, int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 65535)) - 32768,
                ($urandom_range(0, 4) != 0), 1'($urandom), -1, 0, 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog bench did not finish");
        $fatal(1);
    end

endmodule
